// File: rtl/sr_drv_pkg.sv
// Shared types and default constants for the SR latch driver.
// Holds the FSM state encoding and the readback comparison helper.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } drv_state_e;

    localparam int unsigned DEF_PULSE_CYCLES  = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 3;
    localparam int unsigned DEF_MAX_RETRY     = 2;

    // Q == Q_not is an invalid latch state and can never satisfy both terms.
    function automatic logic readback_ok(input logic q, input logic q_not, input logic value);
        return (q == value) && (q_not == ~value);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/status bundle between a requester and the SR latch driver.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both 1.
interface sr_latch_driver_if;
    logic req_valid;
    logic req_ready;
    logic req_value;
    logic done;
    logic err;
    logic value_q;

    modport master (
        output req_valid,
        output req_value,
        input  req_ready,
        input  done,
        input  err,
        input  value_q
    );

    modport slave (
        input  req_valid,
        input  req_value,
        output req_ready,
        output done,
        output err,
        output value_q
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external SR latch with timed S/R pulses, reads it back through
// synchronizers and retries a bounded number of times before flagging an error.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   req,
    input  logic               q_in,
    input  logic               q_not_in,
    output logic               s_out,
    output logic               r_out,
    output drv_state_e         state_o
);

    localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

    drv_state_e state_q;
    logic [3:0] cnt_q;
    logic [2:0] retry_q;
    logic       val_q;
    logic       s_q;
    logic       r_q;
    logic       done_q;
    logic       err_q;
    logic       value_q;
    logic       q_sync;
    logic       q_not_sync;

    sync2 u_sync_q (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (q_in),
        .q_o    (q_sync)
    );

    sync2 u_sync_q_not (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (q_not_in),
        .q_o    (q_not_sync)
    );

    // Async reset clears s_q/r_q immediately, so S/R drop without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            retry_q <= 3'd0;
            val_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            value_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        val_q   <= req.req_value;
                        retry_q <= 3'd0;
                        cnt_q   <= 4'd0;
                        if (readback_ok(q_sync, q_not_sync, req.req_value)) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            value_q <= req.req_value;
                        end else begin
                            state_q <= ST_PULSE;
                            s_q     <= req.req_value;
                            r_q     <= ~req.req_value;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= 4'd0;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    cnt_q <= 4'd0;
                    if (readback_ok(q_sync, q_not_sync, val_q)) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        value_q <= val_q;
                        state_q <= ST_IDLE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_q <= retry_q + 3'd1;
                        s_q     <= val_q;
                        r_q     <= ~val_q;
                        state_q <= ST_PULSE;
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign req.done      = done_q;
    assign req.err       = err_q;
    assign req.value_q   = value_q;
    assign s_out         = s_q;
    assign r_out         = r_q;
    assign state_o       = state_q;

endmodule
